// File: rtl/io_mailbox_responder.sv
// IO-bus mailbox responder: DATA/STATUS/CONTROL/SCRATCH registers over RX and TX FIFOs with a level IRQ.
// Define IO_MAILBOX_LOOPBACK_EN to build the CONTROL[2] TX->RX loopback path.
module io_mailbox_responder #(
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [15:0] io_address,
    input  logic        io_bus_enable,
    input  logic        io_rw,
    input  logic [1:0]  io_byte_enable,
    input  logic [15:0] io_write_data,
    output logic [15:0] io_read_data,
    output logic        io_acknowledge,
    output logic        io_irq,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic [15:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int         PW        = $clog2(FIFO_DEPTH);
    localparam logic [3:0] DEPTH_C   = 4'(FIFO_DEPTH);
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_e;
    typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_CONTROL, REG_SCRATCH} reg_e;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    reg_e        sel_q;
    logic        rw_q;
    logic [1:0]  be_q;
    logic [15:0] wdata_q;

    logic [15:0] rx_mem [FIFO_DEPTH];
    logic [15:0] tx_mem [FIFO_DEPTH];
    logic [PW-1:0] rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q;
    logic [3:0]  rx_cnt_q, tx_cnt_q;
    logic        ovf_q, irq_q;
    logic [2:0]  ctrl_q;
    logic [15:0] scratch_q;

    logic req_hit;
    logic ack, bus_rd, bus_wr;
    logic [15:0] be_mask, wmasked, rdata;
    logic rx_empty, rx_full, tx_empty, tx_full, tx_nonempty;
    logic rx_pop, rx_push, rx_push_req, tx_push, tx_push_req, tx_local_pop;
    logic ovf_set, ovf_clr;
    logic [15:0] rx_push_data, tx_head;

    assign req_hit = io_bus_enable && ((io_address & 16'hFFF8) == BASE_ADDR);

    // NOTE: next-state signals take their hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: if (req_hit) begin
                wcnt_d = 4'd0;
                if (WAIT_CYCLES == 0) state_d = S_ACK;
                else                  state_d = S_WAIT;
            end
            S_WAIT: if (wcnt_q == WAIT_LAST) state_d = S_ACK;
                    else                     wcnt_d  = wcnt_q + 4'd1;
            S_ACK:  state_d = S_HOLD;
            S_HOLD: if (!io_bus_enable) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            sel_q   <= REG_DATA;
            rw_q    <= 1'b0;
            be_q    <= 2'b00;
            wdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (state_q == S_IDLE && req_hit) begin
                sel_q   <= reg_e'(io_address[2:1]);
                rw_q    <= io_rw;
                be_q    <= io_byte_enable;
                wdata_q <= io_write_data;
            end
        end
    end

    assign ack     = (state_q == S_ACK);
    assign bus_rd  = ack & rw_q;
    assign bus_wr  = ack & ~rw_q;
    assign be_mask = {{8{be_q[1]}}, {8{be_q[0]}}};
    assign wmasked = wdata_q & be_mask;

    assign rx_empty    = (rx_cnt_q == 4'd0);
    assign rx_full     = (rx_cnt_q == DEPTH_C);
    assign tx_empty    = (tx_cnt_q == 4'd0);
    assign tx_full     = (tx_cnt_q == DEPTH_C);
    assign tx_nonempty = ~tx_empty;
    assign tx_head     = tx_mem[tx_rp_q];

`ifdef IO_MAILBOX_LOOPBACK_EN
    localparam logic [2:0] CTRL_MASK = 3'b111;
    logic loop_en, lb_move;
    assign loop_en      = ctrl_q[2];
    assign lb_move      = loop_en & tx_nonempty & ~rx_full;
    assign rx_push_req  = loop_en ? lb_move : rx_valid;
    assign rx_push_data = loop_en ? tx_head : rx_data;
    assign tx_local_pop = loop_en ? lb_move : (tx_nonempty & tx_ready);
    assign tx_valid     = tx_nonempty & ~loop_en;
`else
    localparam logic [2:0] CTRL_MASK = 3'b011;
    assign rx_push_req  = rx_valid;
    assign rx_push_data = rx_data;
    assign tx_local_pop = tx_nonempty & tx_ready;
    assign tx_valid     = tx_nonempty;
`endif

    assign tx_data = tx_valid ? tx_head : 16'h0000;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted then.
    assign rx_pop      = bus_rd & (sel_q == REG_DATA) & ~rx_empty;
    assign rx_push     = rx_push_req & (~rx_full | rx_pop);
    assign ovf_set     = rx_push_req & rx_full & ~rx_pop;
    assign ovf_clr     = bus_wr & (sel_q == REG_STATUS) & be_q[0] & wdata_q[4];
    assign tx_push_req = bus_wr & (sel_q == REG_DATA) & (be_q != 2'b00);
    assign tx_push     = tx_push_req & (~tx_full | tx_local_pop);

    // NOTE: FIFO storage has no reset; occupancy is tracked by the reset pointers and counts.
    always_ff @(posedge clk_clk) begin
        if (rx_push) rx_mem[rx_wp_q] <= rx_push_data;
        if (tx_push) tx_mem[tx_wp_q] <= wmasked;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rx_wp_q   <= '0;
            rx_rp_q   <= '0;
            tx_wp_q   <= '0;
            tx_rp_q   <= '0;
            rx_cnt_q  <= 4'd0;
            tx_cnt_q  <= 4'd0;
            ovf_q     <= 1'b0;
            ctrl_q    <= 3'b000;
            scratch_q <= 16'h0000;
            irq_q     <= 1'b0;
        end else begin
            if (rx_push)      rx_wp_q <= rx_wp_q + PW'(1);
            if (rx_pop)       rx_rp_q <= rx_rp_q + PW'(1);
            if (tx_push)      tx_wp_q <= tx_wp_q + PW'(1);
            if (tx_local_pop) tx_rp_q <= tx_rp_q + PW'(1);
            rx_cnt_q <= rx_cnt_q + {3'b000, rx_push} - {3'b000, rx_pop};
            tx_cnt_q <= tx_cnt_q + {3'b000, tx_push} - {3'b000, tx_local_pop};
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
            if (bus_wr && sel_q == REG_CONTROL && be_q[0]) ctrl_q <= wdata_q[2:0] & CTRL_MASK;
            if (bus_wr && sel_q == REG_SCRATCH) scratch_q <= (scratch_q & ~be_mask) | wmasked;
            irq_q <= (ctrl_q[0] & ~rx_empty) | (ctrl_q[1] & tx_empty) | (ctrl_q[0] & ovf_q);
        end
    end

    always_comb begin
        rdata = 16'h0000;
        if (bus_rd) begin
            case (sel_q)
                REG_DATA:    rdata = rx_empty ? 16'h0000 : rx_mem[rx_rp_q];
                REG_STATUS:  rdata = {tx_cnt_q, rx_cnt_q, 3'b000, ovf_q,
                                      tx_full, tx_empty, rx_full, ~rx_empty};
                REG_CONTROL: rdata = {13'h0000, ctrl_q};
                REG_SCRATCH: rdata = scratch_q;
                default:     rdata = 16'h0000;
            endcase
        end
    end

    assign io_read_data   = rdata;
    assign io_acknowledge = ack;
    assign io_irq         = irq_q;

endmodule

// File: tb/tb_io_mailbox_responder.sv
// Directed bench for io_mailbox_responder (BASE_ADDR 0x0040, depth 8, WAIT_CYCLES 3).
// Define IO_MAILBOX_LOOPBACK_EN on both files to exercise the loopback path.
module tb_io_mailbox_responder;

    localparam logic [15:0] A_DATA    = 16'h0040;
    localparam logic [15:0] A_STATUS  = 16'h0042;
    localparam logic [15:0] A_CONTROL = 16'h0044;
    localparam logic [15:0] A_SCRATCH = 16'h0046;
    localparam int          LAT       = 4;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [15:0] io_address;
    logic        io_bus_enable;
    logic        io_rw;
    logic [1:0]  io_byte_enable;
    logic [15:0] io_write_data;
    logic [15:0] io_read_data;
    logic        io_acknowledge;
    logic        io_irq;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int errors = 0;
    int checks = 0;

    io_mailbox_responder #(
        .BASE_ADDR  (16'h0040),
        .FIFO_DEPTH (8),
        .WAIT_CYCLES(3)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .io_address    (io_address),
        .io_bus_enable (io_bus_enable),
        .io_rw         (io_rw),
        .io_byte_enable(io_byte_enable),
        .io_write_data (io_write_data),
        .io_read_data  (io_read_data),
        .io_acknowledge(io_acknowledge),
        .io_irq        (io_irq),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus transfer: counts edges until ack (lat = -1 on timeout), then keeps
    // enable high for 'hold' extra cycles while counting any further acks.
    task automatic bus_xfer(input logic [15:0] addr, input logic rw, input logic [1:0] be,
                            input logic [15:0] wd, input int hold, input logic ready_on_ack,
                            output logic [15:0] rd, output int lat, output int acks);
        lat  = -1;
        acks = 0;
        rd   = 16'h0000;
        @(posedge clk_clk); #1;
        io_address     = addr;
        io_rw          = rw;
        io_byte_enable = be;
        io_write_data  = wd;
        io_bus_enable  = 1'b1;
        for (int c = 1; c <= 12 && lat < 0; c++) begin
            @(posedge clk_clk); #1;
            if (io_acknowledge) begin
                lat  = c;
                acks = 1;
                rd   = io_read_data;
                if (ready_on_ack) tx_ready = 1'b1;
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_clk); #1;
            if (io_acknowledge) acks++;
        end
        io_bus_enable = 1'b0;
        @(posedge clk_clk); #1;
        if (io_acknowledge) acks++;
        if (ready_on_ack) tx_ready = 1'b0;
    endtask

    task automatic push_rx(input logic [15:0] d);
        @(negedge clk_clk);
        rx_valid = 1'b1;
        rx_data  = d;
        @(posedge clk_clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] rd;
        int lat, acks;
        reset_reset_n = 1'b0;
        repeat (3) @(posedge clk_clk);
        #1;
        checks++;
        if ({io_acknowledge, io_irq, tx_valid, io_read_data} !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b irq=%b tx_valid=%b rdata=%h, need all 0",
                     io_acknowledge, io_irq, tx_valid, io_read_data);
        end
        @(negedge clk_clk) reset_reset_n = 1'b1;
        bus_xfer(A_STATUS, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h0004 || lat !== LAT) begin
            errors++;
            $display("FAIL reset_status: got %h lat %0d, need 0004 lat %0d", rd, lat, LAT);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [15:0] rd;
        int lat, acks;
        logic saw_ack;
        bus_xfer(A_SCRATCH, 1'b0, 2'b11, 16'h1234, 0, 1'b0, rd, lat, acks);
        checks++;
        if (lat !== LAT || acks !== 1) begin
            errors++;
            $display("FAIL scratch_pre_write: got lat %0d acks %0d, need %0d and 1", lat, acks, LAT);
        end
        @(posedge clk_clk); #1;
        io_address     = A_SCRATCH;
        io_rw          = 1'b1;
        io_byte_enable = 2'b11;
        io_bus_enable  = 1'b1;
        saw_ack        = 1'b0;
        repeat (2) begin
            @(posedge clk_clk); #1;
            if (io_acknowledge) saw_ack = 1'b1;
        end
        reset_reset_n = 1'b0;
        #1;
        if (io_acknowledge) saw_ack = 1'b1;
        io_bus_enable = 1'b0;
        repeat (3) begin
            @(posedge clk_clk); #1;
            if (io_acknowledge) saw_ack = 1'b1;
        end
        @(negedge clk_clk) reset_reset_n = 1'b1;
        checks++;
        if (saw_ack !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait_no_ack: got ack=%b, need 0", saw_ack);
        end
        bus_xfer(A_SCRATCH, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h0000 || lat !== LAT) begin
            errors++;
            $display("FAIL mid_wait_scratch: got %h lat %0d, need 0000 lat %0d", rd, lat, LAT);
        end
    endtask

    task automatic test_decode();
        logic [15:0] rd;
        int lat, acks;
        bus_xfer(16'h0048, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (lat !== -1 || acks !== 0) begin
            errors++;
            $display("FAIL decode_miss: got lat %0d acks %0d, need no ack", lat, acks);
        end
    endtask

    task automatic test_scratch();
        logic [15:0] rd;
        int lat, acks;
        bus_xfer(A_SCRATCH, 1'b0, 2'b10, 16'hA5C3, 10, 1'b0, rd, lat, acks);
        checks++;
        if (acks !== 1) begin
            errors++;
            $display("FAIL single_ack_held: got %0d acks, need 1", acks);
        end
        bus_xfer(A_SCRATCH, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'hA500) begin
            errors++;
            $display("FAIL scratch_hi_lane: got %h, need a500", rd);
        end
        bus_xfer(A_SCRATCH, 1'b0, 2'b01, 16'h5A5A, 0, 1'b0, rd, lat, acks);
        bus_xfer(A_SCRATCH, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'hA55A) begin
            errors++;
            $display("FAIL scratch_lo_lane: got %h, need a55a", rd);
        end
    endtask

    task automatic test_rx_fifo();
        logic [15:0] rd;
        int lat, acks;
        for (int i = 1; i <= 9; i++) push_rx(16'(i));
        bus_xfer(A_STATUS, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h0817) begin
            errors++;
            $display("FAIL rx_full_status: got %h, need 0817", rd);
        end
        for (int i = 1; i <= 9; i++) begin
            bus_xfer(A_DATA, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
            checks++;
            if (rd !== ((i <= 8) ? 16'(i) : 16'h0000)) begin
                errors++;
                $display("FAIL rx_read_%0d: got %h, need %h", i, rd,
                         (i <= 8) ? 16'(i) : 16'h0000);
            end
        end
        bus_xfer(A_STATUS, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h0014) begin
            errors++;
            $display("FAIL ovf_sticky: got %h, need 0014", rd);
        end
        bus_xfer(A_STATUS, 1'b0, 2'b01, 16'h0010, 0, 1'b0, rd, lat, acks);
        bus_xfer(A_STATUS, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h0004) begin
            errors++;
            $display("FAIL ovf_clear: got %h, need 0004", rd);
        end
    endtask

    task automatic test_irq();
        logic [15:0] rd;
        int lat, acks;
        bus_xfer(A_CONTROL, 1'b0, 2'b11, 16'h0001, 0, 1'b0, rd, lat, acks);
        bus_xfer(A_CONTROL, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h0001 || io_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_ctrl_idle: got ctrl %h irq %b, need 0001 irq 0", rd, io_irq);
        end
        push_rx(16'h0077);
        checks++;
        if (io_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_same_cycle: got %b, need 0", io_irq);
        end
        @(posedge clk_clk); #1;
        checks++;
        if (io_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise: got %b, need 1", io_irq);
        end
        bus_xfer(A_DATA, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h0077 || io_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_pop: got data %h irq %b, need 0077 irq 1", rd, io_irq);
        end
        @(posedge clk_clk); #1;
        checks++;
        if (io_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_fall: got %b, need 0", io_irq);
        end
        bus_xfer(A_CONTROL, 1'b0, 2'b11, 16'h0002, 0, 1'b0, rd, lat, acks);
        checks++;
        if (io_irq !== 1'b0) begin
            errors++;
            $display("FAIL tx_irq_early: got %b, need 0", io_irq);
        end
        @(posedge clk_clk); #1;
        checks++;
        if (io_irq !== 1'b1) begin
            errors++;
            $display("FAIL tx_empty_irq: got %b, need 1", io_irq);
        end
        bus_xfer(A_CONTROL, 1'b0, 2'b11, 16'h0000, 0, 1'b0, rd, lat, acks);
        @(posedge clk_clk); #1;
    endtask

    task automatic test_tx_fifo();
        logic [15:0] rd;
        int lat, acks, k;
        logic [15:0] exp_w [8];
        tx_ready = 1'b0;
        bus_xfer(A_DATA, 1'b0, 2'b00, 16'hFFFF, 0, 1'b0, rd, lat, acks);
        bus_xfer(A_STATUS, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h0004 || acks !== 1) begin
            errors++;
            $display("FAIL tx_be0_nopush: got %h acks %0d, need 0004 acks 1", rd, acks);
        end
        bus_xfer(A_DATA, 1'b0, 2'b01, 16'hAB12, 0, 1'b0, rd, lat, acks);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 16'h0012) begin
            errors++;
            $display("FAIL tx_first_push: got valid %b data %h, need 1 0012", tx_valid, tx_data);
        end
        for (int i = 1; i <= 7; i++)
            bus_xfer(A_DATA, 1'b0, 2'b11, 16'h2000 + 16'(i), 0, 1'b0, rd, lat, acks);
        bus_xfer(A_STATUS, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h8008) begin
            errors++;
            $display("FAIL tx_full_status: got %h, need 8008", rd);
        end
        bus_xfer(A_DATA, 1'b0, 2'b11, 16'h30FF, 0, 1'b1, rd, lat, acks);
        bus_xfer(A_STATUS, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h8008) begin
            errors++;
            $display("FAIL tx_full_push_pop: got %h, need 8008", rd);
        end
        for (int i = 0; i < 7; i++) exp_w[i] = 16'h2001 + 16'(i);
        exp_w[7] = 16'h30FF;
        k = 0;
        tx_ready = 1'b1;
        for (int c = 0; c < 20 && k < 8; c++) begin
            @(negedge clk_clk);
            if (tx_valid) begin
                checks++;
                if (tx_data !== exp_w[k]) begin
                    errors++;
                    $display("FAIL tx_drain_%0d: got %h, need %h", k, tx_data, exp_w[k]);
                end
                k++;
            end
        end
        @(posedge clk_clk); #1;
        tx_ready = 1'b0;
        checks++;
        if (k !== 8 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL tx_drain_count: got %0d words valid %b, need 8 valid 0", k, tx_valid);
        end
    endtask

    task automatic test_control_loopback();
        logic [15:0] rd;
        int lat, acks;
`ifdef IO_MAILBOX_LOOPBACK_EN
        logic saw_tx;
        bus_xfer(A_CONTROL, 1'b0, 2'b11, 16'h0004, 0, 1'b0, rd, lat, acks);
        bus_xfer(A_CONTROL, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h0004) begin
            errors++;
            $display("FAIL lb_ctrl_read: got %h, need 0004", rd);
        end
        bus_xfer(A_DATA, 1'b0, 2'b11, 16'hBEEF, 0, 1'b0, rd, lat, acks);
        saw_tx = tx_valid;
        repeat (4) begin
            @(posedge clk_clk); #1;
            if (tx_valid) saw_tx = 1'b1;
        end
        checks++;
        if (saw_tx !== 1'b0) begin
            errors++;
            $display("FAIL lb_tx_valid: got %b, need 0", saw_tx);
        end
        bus_xfer(A_DATA, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'hBEEF) begin
            errors++;
            $display("FAIL lb_data: got %h, need beef", rd);
        end
`else
        bus_xfer(A_CONTROL, 1'b0, 2'b11, 16'hFFFF, 0, 1'b0, rd, lat, acks);
        bus_xfer(A_CONTROL, 1'b1, 2'b11, 16'h0, 0, 1'b0, rd, lat, acks);
        checks++;
        if (rd !== 16'h0003) begin
            errors++;
            $display("FAIL ctrl_mask: got %h, need 0003", rd);
        end
`endif
        bus_xfer(A_CONTROL, 1'b0, 2'b11, 16'h0000, 0, 1'b0, rd, lat, acks);
    endtask

    initial begin
        reset_reset_n  = 1'b0;
        io_address     = 16'h0000;
        io_bus_enable  = 1'b0;
        io_rw          = 1'b0;
        io_byte_enable = 2'b00;
        io_write_data  = 16'h0000;
        rx_data        = 16'h0000;
        rx_valid       = 1'b0;
        tx_ready       = 1'b0;
        test_reset();
        test_reset_mid_wait();
        test_decode();
        test_scratch();
        test_rx_fifo();
        test_irq();
        test_tx_fifo();
        test_control_loopback();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
